// File: rtl/kernel5x5_sequencer.sv
// Weight-load / pixel-stream sequencer for the kernel5x5 systolic array.
// Optional: define KSEQ_UDR_COUNT_EN to add the udr_cnt bubble counter output.
module kernel5x5_sequencer #(
   parameter int ROWS    = 5,
   parameter int KSIZE   = 5,
   parameter int IMG_W   = 32,
   parameter int OUT_LAT = 14
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic                busy,
   output logic                done,
   input  logic                w_valid,
   output logic                w_ready,
   input  logic [ROWS*4-1:0]   w_data,
   input  logic                px_valid,
   output logic                px_ready,
   input  logic [ROWS*8-1:0]   px_data,
   input  logic [15:0]         bias,
   output logic [ROWS*8-1:0]   arr_in,
   output logic [7:0]          arr_yaux,
   output logic [3:0]          arr_ctrl,
   output logic                res_valid,
   output logic                res_hi,
   output logic                err_udr
`ifdef KSEQ_UDR_COUNT_EN
   ,
   output logic [15:0]         udr_cnt
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_WLOAD, S_RUN, S_DRAIN} state_t;

   localparam logic [7:0]  T_LAST_W = 8'(2*KSIZE-2);
   localparam logic [7:0]  T_LAST_D = 8'(OUT_LAT-1);
   localparam logic [15:0] PX_LAST  = 16'(IMG_W);

   state_t               state;
   logic [7:0]           t;
   logic [15:0]          pix_cnt;
   logic                 phase;
   logic                 cur_valid;
   logic [15:0]          bias_q;
   logic [OUT_LAT-1:0]   pipe_v;
   logic [OUT_LAT-1:0]   pipe_h;

   logic                 w_even;
   logic                 push_v;
   logic                 push_h;
   logic                 streaming;

   assign w_even    = (state == S_WLOAD) && !t[0];
   assign w_ready   = w_even;
   assign px_ready  = (state == S_RUN) && !phase;
   assign streaming = (state == S_RUN) || (state == S_DRAIN);
   assign push_v    = px_ready ? px_valid : ((state == S_RUN) ? cur_valid : 1'b0);
   assign push_h    = streaming && phase;
   assign busy      = (state != S_IDLE);
   assign res_valid = pipe_v[OUT_LAT-1];
   assign res_hi    = pipe_v[OUT_LAT-1] & pipe_h[OUT_LAT-1];

   // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      arr_in   = '0;
      arr_ctrl = 4'b0000;
      arr_yaux = 8'h00;
      case (state)
         S_WLOAD: begin
            if (w_even) begin
               for (int r = 0; r < ROWS; r++) arr_in[8*r +: 8] = {4'b0000, w_data[4*r +: 4]};
               if (!w_valid)            arr_ctrl = 4'b0100;
               else if (t == T_LAST_W)  arr_ctrl = 4'b0001;
            end
         end
         S_RUN, S_DRAIN: begin
            arr_ctrl[2:0] = phase ? 3'b100 : 3'b010;
            arr_ctrl[3]   = pipe_h[OUT_LAT-1];
            arr_yaux      = phase ? bias_q[15:8] : bias_q[7:0];
            if (px_ready && px_valid) arr_in = px_data;
         end
         default: ;
      endcase
   end

   // NOTE: the valid pipeline is reset with the FSM so a mid-pass reset never emits stale res_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         t         <= 8'd0;
         pix_cnt   <= 16'd0;
         phase     <= 1'b0;
         cur_valid <= 1'b0;
         bias_q    <= 16'h0000;
         pipe_v    <= '0;
         pipe_h    <= '0;
         done      <= 1'b0;
         err_udr   <= 1'b0;
`ifdef KSEQ_UDR_COUNT_EN
         udr_cnt   <= 16'h0000;
`endif
      end else begin
         done   <= 1'b0;
         pipe_v <= {pipe_v[OUT_LAT-2:0], push_v};
         pipe_h <= {pipe_h[OUT_LAT-2:0], push_h};
         case (state)
            S_IDLE: begin
               if (start) begin
                  state   <= S_WLOAD;
                  t       <= 8'd0;
                  bias_q  <= bias;
                  err_udr <= 1'b0;
`ifdef KSEQ_UDR_COUNT_EN
                  udr_cnt <= 16'h0000;
`endif
               end
            end
            S_WLOAD: begin
               if (t[0] || w_valid) begin
                  if (t == T_LAST_W) begin
                     state   <= S_RUN;
                     t       <= 8'd0;
                     pix_cnt <= 16'd0;
                     phase   <= 1'b0;
                  end else begin
                     t <= t + 8'd1;
                  end
               end
            end
            S_RUN: begin
               phase <= !phase;
               if (!phase) begin
                  pix_cnt   <= pix_cnt + 16'd1;
                  cur_valid <= px_valid;
                  if (!px_valid) begin
                     err_udr <= 1'b1;
`ifdef KSEQ_UDR_COUNT_EN
                     if (udr_cnt != 16'hFFFF) udr_cnt <= udr_cnt + 16'd1;
`endif
                  end
               end else if (pix_cnt == PX_LAST) begin
                  state <= S_DRAIN;
                  t     <= 8'd0;
               end
            end
            S_DRAIN: begin
               phase <= !phase;
               if (t == T_LAST_D) begin
                  state <= S_IDLE;
                  phase <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  t <= t + 8'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_kernel5x5_sequencer.sv
// Self-checking bench for kernel5x5_sequencer: directed passes with randomized pixels,
// bubbles and weight gaps, compared against a per-cycle schedule derived from the pass rules.
module tb_kernel5x5_sequencer;

   localparam int ROWS    = 5;
   localparam int KSIZE   = 5;
   localparam int IMG_W   = 10;
   localparam int OUT_LAT = 14;
   localparam int PXW     = ROWS*8;
   localparam int WW      = ROWS*4;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic            busy;
   logic            done;
   logic            w_valid;
   logic            w_ready;
   logic [WW-1:0]   w_data;
   logic            px_valid;
   logic            px_ready;
   logic [PXW-1:0]  px_data;
   logic [15:0]     bias;
   logic [PXW-1:0]  arr_in;
   logic [7:0]      arr_yaux;
   logic [3:0]      arr_ctrl;
   logic            res_valid;
   logic            res_hi;
   logic            err_udr;
`ifdef KSEQ_UDR_COUNT_EN
   logic [15:0]     udr_cnt;
`endif

   int n_pass  = 0;
   int n_total = 0;

   kernel5x5_sequencer #(.ROWS(ROWS), .KSIZE(KSIZE), .IMG_W(IMG_W), .OUT_LAT(OUT_LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .w_valid   (w_valid),
      .w_ready   (w_ready),
      .w_data    (w_data),
      .px_valid  (px_valid),
      .px_ready  (px_ready),
      .px_data   (px_data),
      .bias      (bias),
      .arr_in    (arr_in),
      .arr_yaux  (arr_yaux),
      .arr_ctrl  (arr_ctrl),
      .res_valid (res_valid),
      .res_hi    (res_hi),
      .err_udr   (err_udr)
`ifdef KSEQ_UDR_COUNT_EN
      ,
      .udr_cnt   (udr_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_gap(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("idle_done", 64'(done), 64'(0));
         check("idle_busy", 64'(busy), 64'(0));
         check("idle_res_valid", 64'(res_valid), 64'(0));
         check("idle_ctrl", 64'(arr_ctrl), 64'(0));
         step();
      end
   endtask

   // One complete pass: start, weight load (optional w_valid gap), pixel stream, drain.
   task automatic run_pass(input logic [15:0] b, input logic [IMG_W-1:0] bub,
                           input int gap_t, input int gap_len, input int abort_px);
      bit err_exp;
`ifdef KSEQ_UDR_COUNT_EN
      int udr_exp;
      udr_exp = 0;
`endif
      bias  = b;
      start = 1'b1;
      @(negedge clk);
      check("start_idle_busy", 64'(busy), 64'(0));
      step();
      start = 1'b0;
      bias  = 16'($urandom());

      for (int tk = 0; tk <= 2*KSIZE-2; tk++) begin
         if (tk % 2 == 0) begin
            if (tk == gap_t) begin
               for (int g = 0; g < gap_len; g++) begin
                  w_valid = 1'b0;
                  w_data  = WW'($urandom());
                  @(negedge clk);
                  check("wl_gap_ready", 64'(w_ready), 64'(1));
                  check("wl_gap_ctrl", 64'(arr_ctrl), 64'(4'b0100));
                  step();
               end
            end
            w_valid = 1'b1;
            w_data  = {ROWS{4'(tk/2 + 1)}};
            @(negedge clk);
            check("wl_ready", 64'(w_ready), 64'(1));
            check("wl_arr_in", 64'(arr_in), 64'({ROWS{8'(tk/2 + 1)}}));
            check("wl_ctrl", 64'(arr_ctrl), 64'((tk == 2*KSIZE-2) ? 4'b0001 : 4'b0000));
            check("wl_busy", 64'(busy), 64'(1));
            check("wl_err_cleared", 64'(err_udr), 64'(0));
         end else begin
            w_valid = 1'($urandom());
            w_data  = WW'($urandom());
            @(negedge clk);
            check("wl_odd_ready", 64'(w_ready), 64'(0));
            check("wl_odd_arr_in", 64'(arr_in), 64'(0));
            check("wl_odd_ctrl", 64'(arr_ctrl), 64'(0));
         end
         step();
      end
      w_valid = 1'b0;

      err_exp = 1'b0;
      for (int k = 0; k <= 2*IMG_W + OUT_LAT; k++) begin
         int  ph;
         int  pi;
         int  j;
         bit  in_run;
         bit  in_pass;
         bit  lsb;
         bit  bubble;
         bit  exp_v;
         logic [PXW-1:0] exp_in;
         ph      = k % 2;
         pi      = k / 2;
         j       = k - OUT_LAT;
         in_run  = (k < 2*IMG_W);
         in_pass = (k < 2*IMG_W + OUT_LAT);
         lsb     = in_run && (ph == 0);
         bubble  = (lsb && pi < IMG_W) ? bub[pi] : 1'b0;
         exp_v   = (j >= 0 && j < 2*IMG_W) ? !bub[j/2] : 1'b0;

         px_data  = PXW'({$urandom(), $urandom()});
         px_valid = lsb ? !bubble : 1'($urandom());
         start    = (k == 5);
         exp_in   = (lsb && !bubble) ? px_data : '0;
         @(negedge clk);
         if (in_pass) begin
            check("run_busy", 64'(busy), 64'(1));
            check("run_done", 64'(done), 64'(0));
            check("run_px_ready", 64'(px_ready), 64'(lsb));
            check("run_arr_in", 64'(arr_in), 64'(exp_in));
            check("run_ctrl", 64'(arr_ctrl),
                  64'({(j >= 0) ? 1'(j % 2) : 1'b0, (ph == 1) ? 3'b100 : 3'b010}));
            check("run_yaux", 64'(arr_yaux), 64'((ph == 1) ? b[15:8] : b[7:0]));
            check("run_res_valid", 64'(res_valid), 64'(exp_v));
            if (exp_v) check("run_res_hi", 64'(res_hi), 64'(j % 2));
            check("run_err_udr", 64'(err_udr), 64'(err_exp));
`ifdef KSEQ_UDR_COUNT_EN
            check("run_udr_cnt", 64'(udr_cnt), 64'(udr_exp));
`endif
         end else begin
            check("done_pulse", 64'(done), 64'(1));
            check("done_busy", 64'(busy), 64'(0));
            check("done_ctrl", 64'(arr_ctrl), 64'(0));
            check("done_res_valid", 64'(res_valid), 64'(0));
            check("done_err_sticky", 64'(err_udr), 64'(err_exp));
         end
         if (bubble) begin
            err_exp = 1'b1;
`ifdef KSEQ_UDR_COUNT_EN
            udr_exp++;
`endif
         end
         if (abort_px >= 0 && k == 2*abort_px) begin
            start = 1'b0;
            rst   = 1'b1;
            step();
            check("rst_busy", 64'(busy), 64'(0));
            check("rst_res_valid", 64'(res_valid), 64'(0));
            check("rst_ctrl", 64'(arr_ctrl), 64'(0));
            check("rst_done", 64'(done), 64'(0));
            check("rst_px_ready", 64'(px_ready), 64'(0));
            rst = 1'b0;
            idle_gap(3);
            return;
         end
         step();
      end
      start    = 1'b0;
      px_valid = 1'b0;
      idle_gap(OUT_LAT);
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      w_valid  = 1'b0;
      w_data   = '0;
      px_valid = 1'b0;
      px_data  = '0;
      bias     = 16'h0000;
      step();
      step();
      @(negedge clk);
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_done", 64'(done), 64'(0));
      check("reset_ctrl", 64'(arr_ctrl), 64'(0));
      check("reset_arr_in", 64'(arr_in), 64'(0));
      check("reset_w_ready", 64'(w_ready), 64'(0));
      check("reset_px_ready", 64'(px_ready), 64'(0));
      check("reset_res_valid", 64'(res_valid), 64'(0));
      check("reset_err_udr", 64'(err_udr), 64'(0));
      rst = 1'b0;
      step();

      // Clean pass, bias 0x0102, start pulsed mid-RUN.
      run_pass(16'h0102, '0, -1, 0, -1);
      // Bubble on pixel 2, three-cycle weight gap at t=4.
      run_pass(16'($urandom()), IMG_W'(1 << 2), 4, 3, -1);
      // Random bubbles and a random weight gap (possibly on the StoreW column).
      run_pass(16'($urandom()), IMG_W'($urandom() & $urandom()),
               2*int'($urandom_range(0, KSIZE-1)), int'($urandom_range(1, 4)), -1);
      // Reset mid-RUN at pixel 7, then a recovery pass.
      run_pass(16'($urandom()), IMG_W'($urandom() & $urandom()), -1, 0, 7);
      run_pass(16'($urandom()), IMG_W'($urandom() & $urandom()), 8, 2, -1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
